// File: rtl/quad_paddle_frontend_pkg.sv
// Shared encodings for the quadrature paddle front end: Gray state codes,
// step direction codes, error counter width and the transition classifier.
// Used by quad_paddle_frontend; carries no logic of its own.
package quad_paddle_frontend_pkg;

    // 2-bit {A,B} encoder states
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    // step_dir encoding
    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_INC,
        TR_DEC,
        TR_ERR
    } trans_e;

    // Classify one filtered-state transition. Forward order is
    // 00->01->11->10->00; any change of both bits at once is illegal.
    function automatic trans_e classifyTransition(input logic [1:0] prevState,
                                                  input logic [1:0] curState);
        trans_e t;
        t = TR_ERR;
        case ({prevState, curState})
            {S00, S00}, {S01, S01}, {S11, S11}, {S10, S10}: t = TR_NONE;
            {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: t = TR_INC;
            {S00, S10}, {S10, S11}, {S11, S01}, {S01, S00}: t = TR_DEC;
            default:                                        t = TR_ERR;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Purpose: 2-flop synchroniser followed by a stability counter for one encoder pin.
// Latency: a held pin change reaches dout at edge 2+FILT_CYCLES after it is first captured.
// Backpressure: none; free-running, pulses shorter than FILT_CYCLES cycles are dropped.
//
// Ports: clk, rst_n (async active-low), din (raw asynchronous pin), dout (filtered level).
module quad_glitch_filter #(
    parameter int FILT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = (FILT_CYCLES < 2) ? 1 : $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

    logic syncS1;
    logic syncS2;
    logic [CNT_W-1:0] stableCnt;
    logic filtered;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncS1    <= 1'b0;
            syncS2    <= 1'b0;
            stableCnt <= '0;
            filtered  <= 1'b0;
        end else begin
            syncS1 <= din;
            syncS2 <= syncS1;
            if (syncS2 == filtered) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                // This edge is the FILT_CYCLES-th consecutive differing sample.
                filtered  <= syncS2;
                stableCnt <= '0;
            end else begin
                stableCnt <= stableCnt + 1'b1;
            end
        end
    end

    assign dout = filtered;

endmodule

// File: rtl/quad_paddle_frontend.sv
// Purpose: filters and decodes the paddle quadrature pins into a saturating position.
// Latency: a held pin change shows on position/step_valid at edge 3+FILT_CYCLES.
// Backpressure: none; outputs are one-cycle pulses and registered levels.
//
// Ports: clk, rst_n, quadA/quadB (raw pins), frame_tick (frame pulse),
//        position, step_valid, step_dir, quad_err, err_count, velocity.
// Optional macro QUAD_VELOCITY_EN enables the per-frame signed velocity
// accumulator; without it velocity is tied to 0 and frame_tick is unused.
module quad_paddle_frontend
    import quad_paddle_frontend_pkg::*;
#(
    parameter int POS_W       = 9,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 511,
    parameter int POS_INIT    = 256,
    parameter int FILT_CYCLES = 4,
    parameter int VEL_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 quadA,
    input  logic                 quadB,
    input  logic                 frame_tick,
    output logic [POS_W-1:0]     position,
    output logic                 step_valid,
    output logic                 step_dir,
    output logic                 quad_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [VEL_W-1:0]     velocity
);

    localparam logic [POS_W-1:0] P_MIN  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] P_MAX  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] P_INIT = POS_W'(POS_INIT);

    // The first decode must see a filtered value that already reflects the
    // pins held since reset, so arming waits out the full filter latency.
    localparam int ARM_W = $clog2(FILT_CYCLES + 4);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(FILT_CYCLES + 2);

    logic filtA;
    logic filtB;
    logic [1:0] curState;
    logic [1:0] prevState;
    logic armed;
    logic [ARM_W-1:0] armCnt;
    trans_e trans;

    quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) uFiltA (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (quadA),
        .dout  (filtA)
    );

    quad_glitch_filter #(.FILT_CYCLES(FILT_CYCLES)) uFiltB (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (quadB),
        .dout  (filtB)
    );

    assign curState = {filtA, filtB};
    assign trans    = classifyTransition(prevState, curState);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevState  <= S00;
            armed      <= 1'b0;
            armCnt     <= '0;
            position   <= P_INIT;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            quad_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            prevState  <= curState;
            step_valid <= 1'b0;
            quad_err   <= 1'b0;
            if (!armed) begin
                if (armCnt == ARM_LAST) begin
                    armed <= 1'b1;
                end else begin
                    armCnt <= armCnt + 1'b1;
                end
            end else begin
                unique case (trans)
                    TR_INC: begin
                        step_valid <= 1'b1;
                        step_dir   <= DIR_INC;
                        if (position < P_MAX) position <= position + 1'b1;
                    end
                    TR_DEC: begin
                        step_valid <= 1'b1;
                        step_dir   <= DIR_DEC;
                        if (position > P_MIN) position <= position - 1'b1;
                    end
                    TR_ERR: begin
                        quad_err <= 1'b1;
                        if (err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef QUAD_VELOCITY_EN
    localparam logic signed [VEL_W-1:0] VEL_LIM = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_NEG = -VEL_LIM;

    logic signed [VEL_W-1:0] velAcc;
    logic signed [VEL_W-1:0] velAccNext;
    logic signed [VEL_W-1:0] velBase;
    logic signed [VEL_W-1:0] velReg;

    // A step landing on frame_tick belongs to the new window.
    always_comb begin
        velBase    = frame_tick ? '0 : velAcc;
        velAccNext = velBase;
        if (step_valid) begin
            if (step_dir == DIR_INC) begin
                if (velBase != VEL_LIM) velAccNext = velBase + 1'b1;
            end else begin
                if (velBase != VEL_NEG) velAccNext = velBase - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            velAcc <= '0;
            velReg <= '0;
        end else begin
            velAcc <= velAccNext;
            if (frame_tick) velReg <= velAcc;
        end
    end

    assign velocity = velReg;
`else
    logic unusedFrameTick;
    assign unusedFrameTick = frame_tick;
    assign velocity        = '0;
`endif

endmodule

// File: tb/tb_quad_paddle_frontend.sv
// Bench for quad_paddle_frontend: vector records drive the pins, expected
// step/error events go into a queue and are popped by a negedge monitor.
module tb_quad_paddle_frontend;

    localparam int FILT = 4;
    localparam int LAT  = 3 + FILT;

    typedef struct {
        logic a;
        logic b;
        int   hold;
        logic expStep;
        logic expDir;
        logic expErr;
        int   expPos;
        int   expErrCnt;
    } vec_t;

    typedef struct {
        int   cyc;
        logic isErr;
        logic dir;
        int   pos;
        int   errc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       quadA;
    logic       quadB;
    logic       frame_tick;
    logic [8:0] position;
    logic       step_valid;
    logic       step_dir;
    logic       quad_err;
    logic [7:0] err_count;
    logic [7:0] velocity;

    int   cyc = 0;
    int   nVec = 0;
    int   nMis = 0;
    int   modelPos;
    int   modelErr;
    exp_t expQ[$];
    vec_t fwdTab[16];

    quad_paddle_frontend dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .quadA      (quadA),
        .quadB      (quadB),
        .frame_tick (frame_tick),
        .position   (position),
        .step_valid (step_valid),
        .step_dir   (step_dir),
        .quad_err   (quad_err),
        .err_count  (err_count),
        .velocity   (velocity)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] nextState(input logic [1:0] s, input logic dir);
        logic [1:0] n;
        if (dir) begin
            case (s)
                2'b00: n = 2'b01;
                2'b01: n = 2'b11;
                2'b11: n = 2'b10;
                default: n = 2'b00;
            endcase
        end else begin
            case (s)
                2'b00: n = 2'b10;
                2'b10: n = 2'b11;
                2'b11: n = 2'b01;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

    task automatic applyVec(input vec_t v);
        quadA = v.a;
        quadB = v.b;
        if (v.expStep || v.expErr)
            expQ.push_back('{cyc + LAT, v.expErr, v.expDir, v.expPos, v.expErrCnt});
        waitCyc(v.hold);
    endtask

    task automatic buildStep(input logic dir, input int hold, output vec_t v);
        logic [1:0] s;
        s = nextState({quadA, quadB}, dir);
        if (dir) modelPos = (modelPos < 511) ? modelPos + 1 : modelPos;
        else     modelPos = (modelPos > 0)   ? modelPos - 1 : modelPos;
        v = '{s[1], s[0], hold, 1'b1, dir, 1'b0, modelPos, modelErr};
    endtask

    task automatic stepDir(input logic dir);
        vec_t v;
        buildStep(dir, 10, v);
        applyVec(v);
    endtask

    task automatic jumpErr();
        vec_t v;
        modelErr = (modelErr < 255) ? modelErr + 1 : 255;
        v = '{~quadA, ~quadB, 10, 1'b0, 1'b0, 1'b1, modelPos, modelErr};
        applyVec(v);
    endtask

    task automatic pulseTick();
        frame_tick = 1'b1;
        waitCyc(1);
        frame_tick = 1'b0;
    endtask

    // Scoreboard side: every step/error pulse must match the queue head,
    // arriving exactly LAT edges after its pin change.
    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            e = expQ.pop_front();
            nVec++;
            nMis++;
            $display("FAIL missing event: expected at cycle %0d, still absent at cycle %0d", e.cyc, cyc);
        end
        if (rst_n && (step_valid || quad_err)) begin
            if (expQ.size() == 0) begin
                nVec++;
                nMis++;
                $display("FAIL unexpected event: step_valid=%0b quad_err=%0b at cycle %0d, none expected",
                         step_valid, quad_err, cyc);
            end else begin
                e = expQ.pop_front();
                check("event cycle", cyc, e.cyc);
                check("quad_err", int'(quad_err), int'(e.isErr));
                check("step_valid", int'(step_valid), int'(!e.isErr));
                if (!e.isErr) check("step_dir", int'(step_dir), int'(e.dir));
                check("position", int'(position), e.pos);
                check("err_count", int'(err_count), e.errc);
            end
        end
    end

    initial begin
        logic [1:0] s;
        vec_t v;

        // Forward table: four full 00->01->11->10->00 cycles from POS_INIT.
        s = 2'b00;
        for (int i = 0; i < 16; i++) begin
            s = nextState(s, 1'b1);
            fwdTab[i] = '{s[1], s[0], 10, 1'b1, 1'b1, 1'b0, 257 + i, 0};
        end

        rst_n = 1'b0;
        quadA = 1'b0;
        quadB = 1'b0;
        frame_tick = 1'b0;
        modelPos = 256;
        modelErr = 0;
        waitCyc(3);
        check("reset position", int'(position), 256);
        check("reset step_valid", int'(step_valid), 0);
        check("reset step_dir", int'(step_dir), 0);
        check("reset quad_err", int'(quad_err), 0);
        check("reset err_count", int'(err_count), 0);
        check("reset velocity", int'(velocity), 0);
        rst_n = 1'b1;
        waitCyc(20);
        check("idle position", int'(position), 256);

        for (int i = 0; i < 16; i++) applyVec(fwdTab[i]);
        modelPos = fwdTab[15].expPos;
        check("after forward position", int'(position), 272);
        check("after forward err_count", int'(err_count), 0);

        // Reverse down to the floor and three steps past it.
        for (int i = 0; i < 275; i++) stepDir(1'b0);
        check("floor position", int'(position), 0);

        // 3-cycle glitch on quadA must be swallowed by the filter.
        quadA = ~quadA;
        waitCyc(3);
        quadA = ~quadA;
        waitCyc(20);
        check("glitch position", int'(position), 0);
        check("glitch queue drained", expQ.size(), 0);

        // Illegal double-bit jumps: first, then saturation of the counter.
        jumpErr();
        check("first error count", int'(err_count), 1);
        check("error position", int'(position), 0);
        for (int i = 1; i < 300; i++) jumpErr();
        check("saturated err_count", int'(err_count), 255);
        check("error queue drained", expQ.size(), 0);

        // Mid-run reset with pins parked at 11 through release.
        quadA = 1'b1;
        quadB = 1'b1;
        rst_n = 1'b0;
        #2;
        check("async reset position", int'(position), 256);
        check("async reset err_count", int'(err_count), 0);
        check("async reset quad_err", int'(quad_err), 0);
        check("async reset step_valid", int'(step_valid), 0);
        waitCyc(5);
        rst_n = 1'b1;
        modelPos = 256;
        modelErr = 0;
        waitCyc(20);
        check("rearm position", int'(position), 256);
        stepDir(1'b1);
        check("rearm step position", int'(position), 257);

`ifdef QUAD_VELOCITY_EN
        pulseTick();
        for (int i = 0; i < 5; i++) stepDir(1'b1);
        for (int i = 0; i < 2; i++) stepDir(1'b0);
        pulseTick();
        check("velocity window", $signed(velocity), 3);
        // Step pulse lands in the same cycle as frame_tick.
        buildStep(1'b1, LAT, v);
        applyVec(v);
        check("coincident step_valid", int'(step_valid), 1);
        frame_tick = 1'b1;
        waitCyc(1);
        frame_tick = 1'b0;
        check("velocity at coincident tick", $signed(velocity), 0);
        waitCyc(10);
        pulseTick();
        check("velocity seeded window", $signed(velocity), 1);
`else
        for (int i = 0; i < 3; i++) stepDir(1'b1);
        buildStep(1'b0, 10, v);
        applyVec(v);
        pulseTick();
        check("velocity disabled", int'(velocity), 0);
`endif

        waitCyc(10);
        check("final queue drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
